div_unit: RTL and testbench

// - Iterative multi-cycle divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the subtractive counterpart of the
//   32-bit adder in the CPU datapath: one restoring-division step (shift, trial subtract) per clock.
// - Sits beside the ALU in the execute stage. The pipeline stalls while busy=1 and writes result back on result_valid.

---
 rtl/div_unit_pkg.sv | 27 ++
 rtl/div_unit_if.sv | 25 ++
 rtl/div_step.sv | 20 ++
 rtl/div_unit.sv | 107 ++++++++++
 tb/tb_div_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divider: op encodings (funct3[1:0]),
// FSM state encodings and small op-decode helpers used by the divider and the decoder.
package div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic op_is_signed(input op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake: launch request, operands, pipeline kill and
// the busy/result_valid/result return path.
interface div_unit_if #(parameter int WIDTH = 32);
  import div_unit_pkg::*;

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output busy, result_valid, result
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {2'b00, dmag});
  // The true difference is always below dmag, so dropping the top bit is lossless.
  assign rem_out = shifted[WIDTH:0] - (q_bit ? {1'b0, dmag} : '0);

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one restoring step per clock on
// operand magnitudes, signs applied in a final fix-up cycle; divide-by-zero and
// signed overflow bypass the iteration and complete in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  div_unit_if.slave bus
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_p0, state_nxt;
  logic             accept, step_en, fix_en, done_en;
  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH:0]   rem_p0, rem_nxt;
  logic [WIDTH-1:0] quo_p0, dmag_p0;
  logic             is_rem_p0, neg_quo_p0, neg_rem_p0;
  logic             q_bit, sgn_in, special_in;
  logic [WIDTH-1:0] special_res;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  assign sgn_in     = op_is_signed(bus.op);
  assign special_in = (bus.divisor == '0) ||
                      (sgn_in && bus.dividend == MIN_NEG && bus.divisor == '1);
  assign special_res = (bus.divisor == '0)
                     ? (op_is_rem(bus.op) ? bus.dividend : '1)
                     : (op_is_rem(bus.op) ? '0 : MIN_NEG);

  always_ff @(posedge clk) begin
    if (rst) state_p0 <= IDLE;
    else     state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (bus.start && !bus.flush) state_nxt = special_in ? DONE : CALC;
      CALC:    if (bus.flush) state_nxt = IDLE;
               else if (cnt_p0 == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_p0 != IDLE);
    accept   = (state_p0 == IDLE) && bus.start && !bus.flush;
    step_en  = (state_p0 == CALC) && !bus.flush;
    fix_en   = (state_p0 == FIX)  && !bus.flush;
    done_en  = (state_p0 == DONE) && !bus.flush;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_p0),
    .bit_in  (quo_p0[WIDTH-1]),
    .dmag    (dmag_p0),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0           <= '0;
      bus.result_valid <= 1'b0;
      bus.result       <= '0;
    end else begin
      bus.result_valid <= fix_en | done_en;
      if (accept)       cnt_p0 <= '0;
      else if (step_en) cnt_p0 <= cnt_p0 + CNT_W'(1);
      if (fix_en)
        bus.result <= is_rem_p0 ? cond_neg(rem_p0[WIDTH-1:0], neg_rem_p0)
                                : cond_neg(quo_p0, neg_quo_p0);
      else if (done_en)
        bus.result <= quo_p0;
    end
  end

  // Stage p0: operand capture on accept, then one shift/subtract per CALC cycle.
  // On the bypass path quo_p0 carries the finished special-case result.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_rem_p0  <= op_is_rem(bus.op);
      neg_quo_p0 <= sgn_in & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      neg_rem_p0 <= sgn_in & bus.dividend[WIDTH-1];
      dmag_p0    <= cond_neg(bus.divisor, sgn_in & bus.divisor[WIDTH-1]);
      rem_p0     <= '0;
      quo_p0     <= special_in ? special_res
                               : cond_neg(bus.dividend, sgn_in & bus.dividend[WIDTH-1]);
    end else if (step_en) begin
      rem_p0 <= rem_nxt;
      quo_p0 <= {quo_p0[WIDTH-2:0], q_bit};
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a vector table of ops with hand-computed results and
// latencies, plus sequences for start-while-busy, back-to-back, flush and reset.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  typedef struct {
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [17];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge E0.
  task automatic launch(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Counts edges until result_valid is seen, bounded at 100.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.result_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.result_valid) cnt++;
    end
  endtask

  initial begin
    int lat;
    int cnt;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[6]  = '{OP_DIV,  32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{OP_REM,  32'h0000_1234,  32'd0,          32'h0000_1234,  1};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[10] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[11] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[12] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[13] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33};
    vecs[14] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33};
    vecs[15] = '{OP_DIVU, 32'd0,          32'd5,          32'd0,          33};
    vecs[16] = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.op       = OP_DIV;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy",  32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.result_valid), 32'd0);
    check("reset_result", bus.result, 32'd0);

    for (int i = 0; i < 17; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_busy_after_start", i), 32'(bus.busy), 32'd1);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
      check($sformatf("vec%0d_busy_on_valid", i), 32'(bus.busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid_one_cycle", i), 32'(bus.result_valid), 32'd0);
    end

    // start while busy is ignored
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    bus.op = OP_REMU; bus.dividend = 32'd1; bus.divisor = 32'd1; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(lat);
    check("ignored_start_latency", 32'(lat + 5), 32'd33);
    check("ignored_start_result", bus.result, 32'd14);
    count_valid(40, cnt);
    check("ignored_start_no_extra_valid", 32'(cnt), 32'd0);

    // back-to-back start in the valid cycle
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_valid(lat);
    check("b2b_first_result", bus.result, 32'd14);
    launch(OP_REMU, 32'd100, 32'd7);
    check("b2b_second_accepted", 32'(bus.busy), 32'd1);
    wait_valid(lat);
    check("b2b_second_latency", 32'(lat), 32'd33);
    check("b2b_second_result", bus.result, 32'd2);

    // flush mid-CALC
    @(posedge clk);
    @(negedge clk);
    launch(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    count_valid(40, cnt);
    check("flush_no_valid", 32'(cnt), 32'd0);
    check("flush_result_held", bus.result, 32'd2);

    // flush together with start in IDLE drops the start
    bus.op = OP_DIV; bus.dividend = 32'd9; bus.divisor = 32'd0;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    count_valid(10, cnt);
    check("flush_start_no_valid", 32'(cnt), 32'd0);
    check("flush_start_result_held", bus.result, 32'd2);

    // reset mid-CALC
    launch(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    check("rst_mid_valid", 32'(bus.result_valid), 32'd0);
    count_valid(40, cnt);
    check("rst_mid_no_valid", 32'(cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
